// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, redirect priority levels and PC step for the next-PC controller
package pc_seq_pkg;
  typedef enum logic [2:0] {ST_BOOT, ST_RUN, ST_STALL, ST_FLUSH, ST_HALT} state_t;
  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_JUMP = 2'd1;
  localparam logic [1:0] LVL_JREG = 2'd2;
  localparam logic [1:0] LVL_BRANCH = 2'd3;
  localparam logic [31:0] PC_INCREMENT = 32'd4;
endpackage

// File: rtl/pc_redirect_arbiter.sv
// pc_redirect_arbiter: priority select of branch/jr/jump/sequential candidate plus wrap against the fetch limit
module pc_redirect_arbiter
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter logic [31:0] PC_LIMIT = 32'd76
) (
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [1:0]  level,
  output logic [31:0] target,
  output logic [31:0] new_pc,
  output logic        wrap
);
  assign level = branch ? LVL_BRANCH : jump_reg ? LVL_JREG : jump ? LVL_JUMP : LVL_NONE;
  assign redirect = level != LVL_NONE;
  assign target = branch ? branch_target : jump_reg ? jump_reg_target : jump ? jump_target : pc + PC_INCREMENT;
  assign wrap = target > PC_LIMIT;
  assign new_pc = wrap ? RESET_VECTOR : target;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller with stall-time redirect buffering, flush pulses and halt handling
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter logic [31:0] PC_LIMIT = 32'd76,
  parameter int FLUSH_SLOTS = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Halt,
  input  logic        Resume,
  output logic [31:0] NewPC,
  output logic        PCWrite,
  output logic        Flush,
  output logic        Wrapped
);
  localparam logic [1:0] SLOTS = 2'(FLUSH_SLOTS);
  state_t state, state_d;
  logic [1:0] cnt, cnt_d, pend_lvl, pend_lvl_d, arb_level;
  logic [31:0] pend_target, pend_target_d, arb_target, arb_new_pc, new_pc;
  logic arb_redirect, arb_wrap, pc_write, wrap_d;
  pc_redirect_arbiter #(.RESET_VECTOR(RESET_VECTOR), .PC_LIMIT(PC_LIMIT)) u_arb (
    .pc(PC),
    .branch(BranchTaken || pend_lvl == LVL_BRANCH),
    .branch_target(pend_lvl == LVL_BRANCH ? pend_target : BranchTarget),
    .jump_reg(JumpReg || pend_lvl == LVL_JREG),
    .jump_reg_target(pend_lvl == LVL_JREG ? pend_target : JumpRegTarget),
    .jump(Jump || pend_lvl == LVL_JUMP),
    .jump_target(pend_lvl == LVL_JUMP ? pend_target : JumpTarget),
    .redirect(arb_redirect),
    .level(arb_level),
    .target(arb_target),
    .new_pc(arb_new_pc),
    .wrap(arb_wrap)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    pend_lvl_d = pend_lvl;
    pend_target_d = pend_target;
    new_pc = RESET_VECTOR;
    pc_write = 1'b0;
    wrap_d = 1'b0;
    if (Halt) begin
      state_d = ST_HALT;
      pend_lvl_d = LVL_NONE;
      cnt_d = 2'd0;
    end else if (state == ST_BOOT) begin
      pc_write = 1'b1;
      state_d = ST_RUN;
    end else if (state == ST_HALT) begin
      pc_write = Resume;
      state_d = Resume ? ST_RUN : ST_HALT;
    end else if (Stall) begin
      state_d = ST_STALL;
      pend_lvl_d = arb_level;
      pend_target_d = arb_target;
    end else begin
      pc_write = 1'b1;
      new_pc = arb_new_pc;
      wrap_d = arb_wrap;
      pend_lvl_d = LVL_NONE;
      cnt_d = arb_redirect ? SLOTS : cnt - {1'b0, |cnt};
      state_d = (arb_redirect || cnt > 2'd1) ? ST_FLUSH : ST_RUN;
    end
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= ST_BOOT;
      cnt <= 2'd0;
      pend_lvl <= LVL_NONE;
      pend_target <= '0;
      Wrapped <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      pend_lvl <= pend_lvl_d;
      pend_target <= pend_target_d;
      Wrapped <= wrap_d;
    end
  end
  assign NewPC = Reset ? new_pc : RESET_VECTOR;
  assign PCWrite = Reset && pc_write;
  assign Flush = |cnt;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic against a behavioural next-PC model
module tb_pc_sequencer;
  localparam int SLOTS = 2;
  localparam logic [31:0] LIMIT = 32'd76;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pc = '0, bt = '0, jrt = '0, jt = '0;
  logic stall = 1'b0, br = 1'b0, jr = 1'b0, jp = 1'b0, halt = 1'b0, resume = 1'b0;
  logic [31:0] npc;
  logic we, flush, wrapped;
  int errors = 0, checks = 0;
  bit m_boot, m_halt, m_stallmode, m_wrap;
  int m_pprio, m_flush;
  logic [31:0] m_ptgt;
  bit e_we, e_wrapc;
  int e_prio;
  logic [31:0] e_npc, e_tgt;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(32'h0), .PC_LIMIT(LIMIT), .FLUSH_SLOTS(SLOTS)) dut (
    .Clock(clk), .Reset(rst_n), .PC(pc), .Stall(stall),
    .BranchTaken(br), .BranchTarget(bt), .JumpReg(jr), .JumpRegTarget(jrt),
    .Jump(jp), .JumpTarget(jt), .Halt(halt), .Resume(resume),
    .NewPC(npc), .PCWrite(we), .Flush(flush), .Wrapped(wrapped)
  );

  task automatic model_reset();
    m_boot = 1; m_halt = 0; m_stallmode = 0; m_wrap = 0;
    m_pprio = 0; m_flush = 0; m_ptgt = '0;
  endtask

  task automatic eval_model();
    int lp;
    logic [31:0] lt;
    lp = br ? 3 : jr ? 2 : jp ? 1 : 0;
    lt = br ? bt : jr ? jrt : jp ? jt : 32'd0;
    e_prio = lp;
    e_tgt = lt;
    if (m_stallmode && m_pprio > 0 && m_pprio >= lp) begin
      e_prio = m_pprio;
      e_tgt = m_ptgt;
    end
    if (e_prio == 0) e_tgt = pc + 32'd4;
    e_wrapc = e_tgt > LIMIT;
    e_npc = 32'd0;
    e_we = 0;
    if (!rst_n || halt) e_we = 0;
    else if (m_boot) e_we = 1;
    else if (m_halt) e_we = resume;
    else if (!stall) begin
      e_we = 1;
      e_npc = e_wrapc ? 32'd0 : e_tgt;
    end
  endtask

  task automatic tick();
    logic w;
    logic [31:0] n;
    eval_model();
    w = we;
    n = npc;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      m_wrap = 0;
      if (halt) begin
        m_halt = 1; m_boot = 0; m_stallmode = 0; m_pprio = 0; m_flush = 0;
      end else if (m_boot) m_boot = 0;
      else if (m_halt) begin
        if (resume) m_halt = 0;
      end else if (stall) begin
        m_stallmode = 1;
        m_pprio = e_prio;
        if (e_prio > 0) m_ptgt = e_tgt;
      end else begin
        m_stallmode = 0;
        m_wrap = e_wrapc;
        m_pprio = 0;
        if (e_prio > 0) m_flush = SLOTS;
        else if (m_flush > 0) m_flush--;
      end
    end
    #1;
    if (w) pc = n;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (we !== 1'b0 || npc !== 32'd0 || flush !== 1'b0 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: we=%0b npc=%0d flush=%0b wrapped=%0b, want 0 0 0 0", we, npc, flush, wrapped);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (we !== 1'b1 || npc !== 32'(4 * i) || flush !== 1'b0) begin
        errors++;
        $display("FAIL boot_seq[%0d]: we=%0b npc=%0d flush=%0b, want we=1 npc=%0d flush=0", i, we, npc, flush, 4 * i);
      end
      tick();
      #1;
    end
  endtask

  task automatic test_wrap();
    pc = 32'd72;
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd76 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL wrap_edge: we=%0b npc=%0d wrapped=%0b, want we=1 npc=76 wrapped=0", we, npc, wrapped);
    end
    tick();
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd0 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL wrap_over: we=%0b npc=%0d wrapped=%0b, want we=1 npc=0 wrapped=0", we, npc, wrapped);
    end
    tick();
    #1;
    checks++;
    if (wrapped !== 1'b1 || flush !== 1'b0 || npc !== 32'd4) begin
      errors++;
      $display("FAIL wrap_pulse: wrapped=%0b flush=%0b npc=%0d, want wrapped=1 flush=0 npc=4", wrapped, flush, npc);
    end
    tick();
    #1;
    checks++;
    if (wrapped !== 1'b0) begin
      errors++;
      $display("FAIL wrap_once: wrapped=%0b, want 0", wrapped);
    end
  endtask

  task automatic test_redirect();
    pc = 32'd20;
    br = 1; bt = 32'd40; jp = 1; jt = 32'd60;
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd40 || flush !== 1'b0) begin
      errors++;
      $display("FAIL redirect_prio: we=%0b npc=%0d flush=%0b, want we=1 npc=40 flush=0", we, npc, flush);
    end
    tick();
    br = 0; jp = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (flush !== (i < SLOTS) || we !== 1'b1) begin
        errors++;
        $display("FAIL redirect_flush[%0d]: flush=%0b we=%0b, want flush=%0b we=1", i, flush, we, i < SLOTS);
      end
      tick();
      #1;
    end
  endtask

  task automatic test_stall_pend();
    stall = 1; jp = 1; jt = 32'd48;
    #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL stall_c1: we=%0b, want 0", we);
    end
    tick();
    jp = 0; br = 1; bt = 32'd32;
    #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL stall_c2: we=%0b, want 0", we);
    end
    tick();
    br = 0;
    #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL stall_c3: we=%0b, want 0", we);
    end
    tick();
    stall = 0;
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd32 || flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: we=%0b npc=%0d flush=%0b, want we=1 npc=32 flush=0", we, npc, flush);
    end
    tick();
    #1;
    checks++;
    if (flush !== 1'b1 || npc !== 32'd36) begin
      errors++;
      $display("FAIL stall_flush: flush=%0b npc=%0d, want flush=1 npc=36", flush, npc);
    end
    repeat (2) tick();
  endtask

  task automatic test_halt();
    pc = 32'd16;
    halt = 1;
    #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: we=%0b, want 0", we);
    end
    tick();
    halt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (we !== 1'b0 || flush !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold[%0d]: we=%0b flush=%0b, want 0 0", i, we, flush);
      end
      tick();
    end
    halt = 1; resume = 1;
    #1;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL halt_and_resume: we=%0b, want 0", we);
    end
    tick();
    halt = 0;
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd0) begin
      errors++;
      $display("FAIL halt_resume: we=%0b npc=%0d, want we=1 npc=0", we, npc);
    end
    tick();
    resume = 0;
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd4) begin
      errors++;
      $display("FAIL halt_after: we=%0b npc=%0d, want we=1 npc=4", we, npc);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    jp = 1; jt = 32'd8;
    #1;
    tick();
    jp = 0; stall = 1; br = 1; bt = 32'd60;
    #1;
    checks++;
    if (flush !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: flush=%0b we=%0b, want flush=1 we=0", flush, we);
    end
    tick();
    rst_n = 0; stall = 0; br = 0;
    #1;
    model_reset();
    checks++;
    if (flush !== 1'b0 || we !== 1'b0 || npc !== 32'd0 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: flush=%0b we=%0b npc=%0d wrapped=%0b, want 0 0 0 0", flush, we, npc, wrapped);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL mid_boot: we=%0b npc=%0d flush=%0b, want we=1 npc=0 flush=0", we, npc, flush);
    end
    tick();
    #1;
    checks++;
    if (we !== 1'b1 || npc !== 32'd4 || flush !== 1'b0) begin
      errors++;
      $display("FAIL mid_pend_lost: we=%0b npc=%0d flush=%0b, want we=1 npc=4 flush=0", we, npc, flush);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 7) == 0;
      jr = $urandom_range(0, 7) == 0;
      jp = $urandom_range(0, 7) == 0;
      halt = $urandom_range(0, 39) == 0;
      resume = $urandom_range(0, 2) == 0;
      bt = 32'($urandom_range(0, 25) * 4);
      jrt = 32'($urandom_range(0, 25) * 4);
      jt = 32'($urandom_range(0, 25) * 4);
      #1;
      eval_model();
      checks++;
      if (we !== e_we || (e_we && npc !== e_npc) || flush !== (m_flush > 0) || wrapped !== m_wrap) begin
        errors++;
        $display("FAIL random[%0d]: we=%0b npc=%0d flush=%0b wrapped=%0b, want we=%0b npc=%0d flush=%0b wrapped=%0b",
                 i, we, npc, flush, wrapped, e_we, e_npc, m_flush > 0, m_wrap);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_redirect();
    test_stall_pend();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
